// File: rtl/kgp_shift_pkg.sv
// rtl/kgp_shift_pkg.sv - shared op/state encodings and default sizing for the KGP-RISC shift unit
package kgp_shift_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_STEP  = 1;

  typedef enum logic [1:0] {
    SHOP_SLL  = 2'b00,
    SHOP_SRL  = 2'b01,
    SHOP_SRA  = 2'b10,
    SHOP_PASS = 2'b11
  } shop_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step_slice.sv
// rtl/shift_step_slice.sv - combinational shift of one value by 0..STEP bits in the requested direction
module shift_step_slice
  import kgp_shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = DEFAULT_STEP,
  parameter int AW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  shop_e            op,
  input  logic [AW-1:0]    amount,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  logic              fill_bit;
  logic [2*WIDTH-1:0] ext;

  always_comb begin
    fill_bit = (op == SHOP_SRA) & fill;
    // Right shifts pull fill bits in from an upper half of copies.
    ext      = {{WIDTH{fill_bit}}, value} >> amount;
    result   = value;
    unique case (op)
      SHOP_SLL:          result = value << amount;
      SHOP_SRL, SHOP_SRA: result = ext[WIDTH-1:0];
      default:           result = value;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - iterative shll/shrl/shra unit driving a negedge destination register
// Optional SHIFT_SATURATE_FAST_EN: out-of-range shift amounts complete without iterating.
module seq_shift_unit
  import kgp_shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int STEP  = DEFAULT_STEP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [WIDTH-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic             writeEnable,
  output logic [WIDTH-1:0] writeData
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = $clog2(STEP + 1);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    WIDTH_N = CW'(WIDTH);
  localparam logic [CW-1:0]    STEP_N  = CW'(STEP);

  state_e           state_q, state_d;
  shop_e            op_q, op_d;
  logic             fill_q, fill_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    rem_q, rem_d;

  logic             sat;
  logic             fast_sat;
  logic [CW-1:0]    n;
  logic [CW-1:0]    step_amt;
  logic [WIDTH-1:0] slice_out;

  shift_step_slice #(.WIDTH(WIDTH), .STEP(STEP), .AW(AW)) u_slice (
    .value  (data_q),
    .op     (op_q),
    .amount (AW'(step_amt)),
    .fill   (fill_q),
    .result (slice_out)
  );

  always_comb begin
    sat      = (shamt >= WIDTH_V);
    n        = sat ? WIDTH_N : CW'(shamt);
    step_amt = (rem_q < STEP_N) ? rem_q : STEP_N;
`ifdef SHIFT_SATURATE_FAST_EN
    fast_sat = sat && (shop_e'(op) != SHOP_PASS);
`else
    fast_sat = 1'b0;
`endif
    state_d = state_q;
    op_d    = op_q;
    fill_d  = fill_q;
    data_d  = data_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = shop_e'(op);
          fill_d = operand[WIDTH-1];
          data_d = operand;
          rem_d  = n;
          if (fast_sat) begin
            data_d  = (shop_e'(op) == SHOP_SRA && operand[WIDTH-1]) ? '1 : '0;
            rem_d   = '0;
            state_d = ST_DONE;
          end else if (shop_e'(op) == SHOP_PASS || n == '0) begin
            rem_d   = '0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        data_d = slice_out;
        rem_d  = rem_q - step_amt;
        if (rem_q == step_amt) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q    <= SHOP_SLL;
      fill_q  <= 1'b0;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

  assign busy        = (state_q == ST_SHIFT);
  assign done        = (state_q == ST_DONE);
  assign writeEnable = done;
  assign writeData   = data_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb/tb_seq_shift_unit.sv - scoreboard bench for seq_shift_unit (STEP=1 and STEP=4 instances)
module tb_seq_shift_unit;

`ifdef SHIFT_SATURATE_FAST_EN
  localparam int SAT_L1 = 0;
  localparam int SAT_L4 = 0;
`else
  localparam int SAT_L1 = 32;
  localparam int SAT_L4 = 8;
`endif

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, start4 = 1'b0;
  logic [1:0]  op = 2'b00, op4 = 2'b00;
  logic [31:0] operand = '0, shamt = '0, operand4 = '0, shamt4 = '0;
  logic        busy, done, writeEnable, busy4, done4, we4;
  logic [31:0] writeData, wd4;
  logic [31:0] dreg;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  exp_t        q4[$];

  seq_shift_unit #(.WIDTH(32), .STEP(1)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .operand(operand), .shamt(shamt),
    .busy(busy), .done(done), .writeEnable(writeEnable), .writeData(writeData)
  );

  seq_shift_unit #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op(op4), .operand(operand4), .shamt(shamt4),
    .busy(busy4), .done(done4), .writeEnable(we4), .writeData(wd4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the downstream negative-edge destination register.
  always @(negedge clk) begin
    if (rst) dreg <= '0;
    else if (writeEnable) dreg <= writeData;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic mon1();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && writeEnable) begin
        if (q.size() == 0) begin
          chk("unexpected_we", writeData, 32'hxxxx_xxxx);
        end else begin
          e = q.pop_front();
          chk("writeData", writeData, e.data);
          chk("latency", 32'(cyc), 32'(e.cyc));
          chk("done", {31'b0, done}, 32'd1);
        end
      end
    end
  endtask

  task automatic mon4();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && we4) begin
        if (q4.size() == 0) begin
          chk("unexpected_we4", wd4, 32'hxxxx_xxxx);
        end else begin
          e = q4.pop_front();
          chk("writeData4", wd4, e.data);
          chk("latency4", 32'(cyc), 32'(e.cyc));
          chk("done4", {31'b0, done4}, 32'd1);
        end
      end
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] s,
                       input logic [31:0] d, input int lat);
    op = o; operand = a; shamt = s; start = 1'b1;
    q.push_back('{d, cyc + 1 + lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic issue4(input logic [1:0] o, input logic [31:0] a, input logic [31:0] s,
                        input logic [31:0] d, input int lat);
    op4 = o; operand4 = a; shamt4 = s; start4 = 1'b1;
    q4.push_back('{d, cyc + 1 + lat});
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0 && q4.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0 || q4.size() != 0) begin
      chk("drain_timeout", 32'(q.size() + q4.size()), 32'd0);
      q.delete();
      q4.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int bc;
    fork
      mon1();
      mon4();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_we", {31'b0, writeEnable}, 32'd0);
    chk("rst_data", writeData, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(2'b00, 32'h0000_0001, 32'd4, 32'h0000_0010, 4);
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (writeEnable) break;
      if (busy) bc++;
      @(negedge clk);
    end
    chk("busy_cycles", 32'(bc), 32'd4);
    drain();
    chk("dest_reg", dreg, 32'h0000_0010);

    issue(2'b10, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 31);        drain();
    issue(2'b01, 32'hDEAD_BEEF, 32'd40, 32'h0000_0000, SAT_L1);    drain();
    issue(2'b00, 32'h1234_5678, 32'd0, 32'h1234_5678, 0);          drain();
    issue(2'b11, 32'h1234_5678, 32'd7, 32'h1234_5678, 0);          drain();
    issue(2'b10, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF, SAT_L1);   drain();
    issue(2'b10, 32'h4000_0000, 32'd4, 32'h0400_0000, 4);          drain();
    issue(2'b00, 32'h0000_0001, 32'd32, 32'h0000_0000, SAT_L1);    drain();
    issue(2'b01, 32'h8000_0000, 32'd31, 32'h0000_0001, 31);        drain();
    issue(2'b00, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0, SAT_L1);     drain();

    // Reset during the third SHIFT cycle must abort without a strobe.
    op = 2'b00; operand = 32'h0000_0001; shamt = 32'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_data", writeData, 32'd0);
    chk("midrst_we", {31'b0, writeEnable}, 32'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    issue(2'b01, 32'h0000_0100, 32'd4, 32'h0000_0010, 4);          drain();

    // New start while busy is ignored.
    issue(2'b00, 32'h0000_0003, 32'd5, 32'h0000_0060, 5);
    repeat (2) @(negedge clk);
    op = 2'b01; operand = 32'h0000_FFFF; shamt = 32'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Start held through DONE: second op accepted at the first IDLE edge.
    op = 2'b00; operand = 32'h0000_0001; shamt = 32'd2; start = 1'b1;
    q.push_back('{32'h0000_0004, cyc + 3});
    q.push_back('{32'h0000_0010, cyc + 8});
    @(negedge clk);
    op = 2'b01; operand = 32'h0000_0080; shamt = 32'd3;
    repeat (4) @(negedge clk);
    start = 1'b0;
    drain();

    issue4(2'b01, 32'hF000_0000, 32'd6, 32'h03C0_0000, 2);         drain();
    issue4(2'b00, 32'h0000_0001, 32'd32, 32'h0000_0000, SAT_L4);   drain();
    issue4(2'b10, 32'h8000_0000, 32'd9, 32'hFFC0_0000, 3);         drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
